instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Front-end fetch stage that drives the instruction memory port directly and feeds decode. After reset it runs a boot-load phase that writes program words into the instruction memory. It then fetches sequentially from RESET_PC and buffers words with their PC in a 2-entry queue behind a valid/ready handshake. It also supports branch redirect and stops on a HALT word.

## Interface
- ADDR_W, 65, width of the memory address and PC.
- DATA_W, 64, instruction word width; memory data ports are DATA_W+1 wide.
- RESET_PC, 0, first load and first fetch address.
- PC_STEP, 2, address increment per word; the memory indexes words with address[8:1].
- HALT_WORD, 64'hFFFF_FFFF_FFFF_FFFF, instruction value that stops fetch.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  boot-load word present (LOAD state only).
- ld_data  in  DATA_W  boot-load word.
- ld_done  in  1  final load cycle; may coincide with ld_valid.
- imem_address  out  ADDR_W  memory address (load pointer in LOAD, PC otherwise).
- imem_write_data  out  DATA_W+1  {1'b0, ld_data}.
- imem_write_en  out  1  ld_valid while in LOAD, else 0.
- imem_read_en  out  1  fetch strobe.
- imem_read_data  in  DATA_W+1  combinational read data; bit DATA_W ignored.
- redir_valid  in  1  redirect request.
- redir_pc  in  ADDR_W  redirect target.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  head PC.
- running  out  1  high in RUN.
- halted  out  1  high in HALT.

## Operation
- States: LOAD (reset state), RUN, HALT.
- LOAD
  - Read strobe held low: imem_read_en = 0.
  - Write address: imem_address = ld_ptr. ld_ptr resets to RESET_PC and advances by PC_STEP on each ld_valid.
  - End of load: ld_done moves to RUN and sets pc = RESET_PC. A word presented with ld_done in the same cycle is still written.
  - Redirect ignored. No queue activity.
  - Loading more than 256 words overwrites the memory from word 0 (mod-512 aliasing). No error is flagged.
- RUN
  - Fetch condition: imem_read_en = 1 when the queue can accept, i.e. count < 2, or count == 2 and a pop occurs this cycle.
  - On a fetch edge: enqueue {imem_read_data[DATA_W-1:0], pc}, then pc <= pc + PC_STEP, modulo 2^ADDR_W.
  - If the fetched word equals HALT_WORD, it is still enqueued and the next state is HALT.
- HALT
  - imem_read_en = 0. The queue keeps draining to decode.
  - redir_valid returns to RUN.
- Redirect (RUN or HALT)
  - Effect at the next edge: queue flushed (count = 0), pc <= redir_pc, state RUN.
  - Any fetch or pop in that cycle is discarded; redirect has priority over all other events, including a HALT_WORD fetched in the same cycle.
- Queue
  - 2 entries, registered head. inst_valid = (count != 0).
  - Pop occurs when inst_valid && inst_ready.
  - Enqueue and pop in the same cycle keep count unchanged.
  - inst_data and inst_pc hold their value while inst_valid = 1 and inst_ready = 0.
- Width rules: PC and pointer are plain ADDR_W unsigned adds with silent wrap.

## Timing
- Reset values: state LOAD; ld_ptr = pc = RESET_PC; count 0.
- Outputs during reset:
  - inst_valid 0; inst_data 0; inst_pc 0; running 0; halted 0.
  - imem_read_en 0; imem_address RESET_PC.
  - imem_write_en follows ld_valid.
- rst_n asserted mid-operation immediately clears the queue and returns to LOAD. Memory contents are untouched.
- Memory read is same-cycle. The word is captured on the edge ending the fetch cycle, and inst_valid rises the following cycle.
- Latency:
  - ld_done edge to first imem_read_en: 0 cycles (the next cycle is RUN).
  - First inst_valid: 1 cycle after the first fetch.
- Throughput: one instruction per cycle with inst_ready held high.
- With inst_ready low, fetch stops after 2 words. Fetch resumes in the same cycle inst_ready rises.
- Redirect: first fetch from redir_pc occurs in the cycle after redir_valid. inst_valid rises one cycle later.

## Test plan
- Boot load: load words 0x11, 0x22, 0x33, with ld_done on the third word.
  - Writes to addresses 0, 2, 4.
  - Decode then receives (0x11, pc 0), (0x22, pc 2), (0x33, pc 4) on consecutive cycles.
- Backpressure: inst_ready held low for 5 cycles after the first fetch.
  - Exactly 2 fetches occur and the head stays (0x11, 0).
  - On release, the stream resumes with no loss or duplication.
- Redirect with a full queue: redir_valid with redir_pc = 0x20.
  - inst_valid drops the next cycle.
  - The next delivered word carries pc 0x20.
- Halt: HALT_WORD loaded at address 6.
  - It is delivered with pc 6, and fetch stops with halted = 1.
  - A redirect to 0 resumes RUN from pc 0.
- Reset mid-run: pulse rst_n low while count == 2.
  - All outputs return to reset values asynchronously.
  - The FSM is in LOAD and imem_read_en = 0 until ld_done.
- Wrap: redirect to pc 2^65 − 2.
  - The next fetched PC is 0.
  - Memory address bits [8:1] go 255 → 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch front end: boot-loads the instruction memory, then streams words and
// their PCs to decode through a 2-entry queue, with redirect and HALT-word stop.
module instruction_fetch #(
  parameter int                ADDR_W    = 65,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(2),
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic [ADDR_W-1:0] imem_address,
  output logic [DATA_W:0]   imem_write_data,
  output logic              imem_write_en,
  output logic              imem_read_en,
  input  logic [DATA_W:0]   imem_read_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              running,
  output logic              halted
);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ld_ptr_reg, ld_ptr_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [1:0]        count_reg, count_next;
  logic [DATA_W-1:0] head_data_reg, head_data_next;
  logic [ADDR_W-1:0] head_pc_reg, head_pc_next;
  logic [DATA_W-1:0] tail_data_reg, tail_data_next;
  logic [ADDR_W-1:0] tail_pc_reg, tail_pc_next;

  logic              redirect;
  logic              pop;
  logic              fetch;
  logic [DATA_W-1:0] fetch_word;
  logic              read_spare_unused;

  assign fetch_word        = imem_read_data[DATA_W-1:0];
  assign read_spare_unused = imem_read_data[DATA_W];

  assign inst_valid = (count_reg != 2'd0);
  assign inst_data  = head_data_reg;
  assign inst_pc    = head_pc_reg;

  assign redirect = (state_reg != ST_LOAD) && redir_valid;
  assign pop      = inst_valid && inst_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign fetch    = (state_reg == ST_RUN) && ((count_reg < 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD: if (ld_done) state_next = ST_RUN;
      ST_RUN: begin
        if (redirect)
          state_next = ST_RUN;
        else if (fetch && (fetch_word == HALT_WORD))
          state_next = ST_HALT;
      end
      ST_HALT: if (redirect) state_next = ST_RUN;
      default: state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    running         = (state_reg == ST_RUN);
    halted          = (state_reg == ST_HALT);
    imem_read_en    = fetch;
    imem_write_en   = (state_reg == ST_LOAD) && ld_valid;
    imem_write_data = {1'b0, ld_data};
    imem_address    = (state_reg == ST_LOAD) ? ld_ptr_reg : pc_reg;
  end

  always_comb begin
    ld_ptr_next    = ld_ptr_reg;
    pc_next        = pc_reg;
    count_next     = count_reg;
    head_data_next = head_data_reg;
    head_pc_next   = head_pc_reg;
    tail_data_next = tail_data_reg;
    tail_pc_next   = tail_pc_reg;
    if (state_reg == ST_LOAD) begin
      if (ld_valid) ld_ptr_next = ld_ptr_reg + PC_STEP;
      if (ld_done)  pc_next     = RESET_PC;
    end else if (redirect) begin
      // Redirect discards both the fetched word and any pop this cycle.
      pc_next    = redir_pc;
      count_next = 2'd0;
    end else begin
      if (fetch) pc_next = pc_reg + PC_STEP;
      case ({fetch, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            head_data_next = fetch_word;
            head_pc_next   = pc_reg;
          end else begin
            tail_data_next = fetch_word;
            tail_pc_next   = pc_reg;
          end
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          head_data_next = tail_data_reg;
          head_pc_next   = tail_pc_reg;
          count_next     = count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_data_next = fetch_word;
            head_pc_next   = pc_reg;
          end else begin
            head_data_next = tail_data_reg;
            head_pc_next   = tail_pc_reg;
            tail_data_next = fetch_word;
            tail_pc_next   = pc_reg;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr_reg    <= RESET_PC;
      pc_reg        <= RESET_PC;
      count_reg     <= 2'd0;
      head_data_reg <= '0;
      head_pc_reg   <= '0;
      tail_data_reg <= '0;
      tail_pc_reg   <= '0;
    end else begin
      ld_ptr_reg    <= ld_ptr_next;
      pc_reg        <= pc_next;
      count_reg     <= count_next;
      head_data_reg <= head_data_next;
      head_pc_reg   <= head_pc_next;
      tail_data_reg <= tail_data_next;
      tail_pc_reg   <= tail_pc_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: external 256-word memory, queue-based reference
// model compared every cycle, plus directed literal checks.
module tb_instruction_fetch;

  localparam logic [63:0] HALT = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [63:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic [64:0] imem_address;
  logic [64:0] imem_write_data;
  logic        imem_write_en;
  logic        imem_read_en;
  logic [64:0] imem_read_data;
  logic        redir_valid = 1'b0;
  logic [64:0] redir_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_data;
  logic [64:0] inst_pc;
  logic        running;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_done(ld_done),
    .imem_address(imem_address), .imem_write_data(imem_write_data),
    .imem_write_en(imem_write_en), .imem_read_en(imem_read_en),
    .imem_read_data(imem_read_data),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory seen by the DUT; the spare top bit is driven high to prove it is ignored.
  logic [63:0] mem [256];
  assign imem_read_data = {1'b1, mem[imem_address[8:1]]};
  always @(posedge clk) if (imem_write_en) mem[imem_address[8:1]] <= imem_write_data[63:0];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0=LOAD 1=RUN 2=HALT, decode queue as a plain queue.
  typedef struct packed { logic [63:0] d; logic [64:0] pc; } ent_t;
  ent_t        mq[$];
  int          mst = 0;
  logic [64:0] mptr = '0;
  logic [64:0] mpc = '0;
  logic [63:0] mmem [256];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); mst = 0; mptr = '0; mpc = '0;
    end else if (mst == 0) begin
      if (ld_valid) begin mmem[mptr[8:1]] = ld_data; mptr = mptr + 65'd2; end
      if (ld_done) begin mst = 1; mpc = '0; end
    end else if (redir_valid) begin
      mq.delete(); mpc = redir_pc; mst = 1;
    end else begin
      bit do_pop, do_fetch;
      logic [63:0] w;
      do_pop   = (mq.size() > 0) && inst_ready;
      do_fetch = (mst == 1) && (mq.size() < 2 || (mq.size() == 2 && inst_ready));
      if (do_pop) void'(mq.pop_front());
      if (do_fetch) begin
        w = mmem[mpc[8:1]];
        mq.push_back('{d: w, pc: mpc});
        mpc = mpc + 65'd2;
        if (w == HALT) mst = 2;
      end
    end
  end

  // Decode-side log of accepted instructions.
  logic [63:0] dl_d[$];
  logic [64:0] dl_pc[$];
  int          fetch_cnt = 0;

  always @(negedge clk) begin
    logic exp_rd;
    exp_rd = (mst == 1) && (mq.size() < 2 || (mq.size() == 2 && inst_ready));
    chk("read_en", imem_read_en, exp_rd);
    chk("address", imem_address, (mst == 0) ? mptr : mpc);
    chk("write_en", imem_write_en, (mst == 0) && ld_valid);
    if ((mst == 0) && ld_valid) chk("write_data", imem_write_data, {1'b0, ld_data});
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("inst_data", inst_data, mq[0].d);
      chk("inst_pc", inst_pc, mq[0].pc);
    end
    chk("running", running, mst == 1);
    chk("halted", halted, mst == 2);
    if (imem_read_en) fetch_cnt++;
    if (inst_valid && inst_ready) begin
      dl_d.push_back(inst_data);
      dl_pc.push_back(inst_pc);
      $display("deliver pc=%h data=%h", inst_pc, inst_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [63:0] d, input logic done);
    step();
    ld_valid = 1'b1; ld_data = d; ld_done = done;
  endtask

  logic [64:0] top_pc;
  bit          seen_halt;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; mmem[i] = '0; end
    top_pc = {65{1'b1}} ^ 65'd1;

    // Reset values and write_en following ld_valid during reset
    step();
    ld_valid = 1'b1; #1;
    chk("rst_write_en", imem_write_en, 1'b1);
    ld_valid = 1'b0; #1;
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_read_en", imem_read_en, 1'b0);
    chk("rst_address", imem_address, 65'd0);
    chk("rst_running", running, 1'b0);
    step();
    rst_n = 1'b1;

    // Boot load 0x11, 0x22, 0x33
    load_word(64'h11, 1'b0); #1 chk("ld_addr0", imem_address, 65'd0);
    load_word(64'h22, 1'b0); #1 chk("ld_addr1", imem_address, 65'd2);
    load_word(64'h33, 1'b1); #1 chk("ld_addr2", imem_address, 65'd4);
    step();
    ld_valid = 1'b0; ld_done = 1'b0; fetch_cnt = 0; #1;
    chk("first_fetch_en", imem_read_en, 1'b1);
    chk("first_fetch_addr", imem_address, 65'd0);

    // Backpressure: exactly two fetches, head held
    repeat (5) step();
    chk("bp_fetch_cnt", fetch_cnt, 2);
    chk("bp_head_data", inst_data, 64'h11);
    chk("bp_head_pc", inst_pc, 65'd0);
    chk("bp_model_size", mq.size(), 2);
    dl_d.delete(); dl_pc.delete();
    inst_ready = 1'b1; #1;
    chk("bp_resume_en", imem_read_en, 1'b1);
    repeat (3) step();
    chk("stream_len", dl_d.size(), 3);
    if (dl_d.size() == 3) begin
      chk("stream0_d", dl_d[0], 64'h11); chk("stream0_pc", dl_pc[0], 65'd0);
      chk("stream1_d", dl_d[1], 64'h22); chk("stream1_pc", dl_pc[1], 65'd2);
      chk("stream2_d", dl_d[2], 64'h33); chk("stream2_pc", dl_pc[2], 65'd4);
    end

    // Redirect with a full queue
    inst_ready = 1'b0;
    repeat (3) step();
    chk("rd_full_valid", inst_valid, 1'b1);
    redir_valid = 1'b1; redir_pc = 65'h20;
    step();
    redir_valid = 1'b0; #1;
    chk("rd_valid_drop", inst_valid, 1'b0);
    chk("rd_fetch_addr", imem_address, 65'h20);
    dl_d.delete(); dl_pc.delete();
    inst_ready = 1'b1;
    repeat (2) step();
    chk("rd_len", dl_pc.size(), 1);
    if (dl_pc.size() >= 1) chk("rd_pc", dl_pc[0], 65'h20);

    // Reset mid-run with a full queue
    inst_ready = 1'b0;
    repeat (3) step();
    chk("mr_model_size", mq.size(), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_inst_valid", inst_valid, 1'b0);
    chk("mr_inst_data", inst_data, 64'h0);
    chk("mr_inst_pc", inst_pc, 65'd0);
    chk("mr_running", running, 1'b0);
    chk("mr_halted", halted, 1'b0);
    chk("mr_read_en", imem_read_en, 1'b0);
    chk("mr_address", imem_address, 65'd0);
    #1 rst_n = 1'b1;
    repeat (3) step();
    chk("mr_load_read_en", imem_read_en, 1'b0);

    // Reload with HALT at address 6
    load_word(64'h11, 1'b0);
    load_word(64'h22, 1'b0);
    load_word(64'h33, 1'b0);
    load_word(HALT, 1'b1);
    step();
    ld_valid = 1'b0; ld_done = 1'b0; inst_ready = 1'b1;
    dl_d.delete(); dl_pc.delete();
    seen_halt = 1'b0;
    for (int i = 0; i < 20 && !seen_halt; i++) begin
      step();
      seen_halt = halted;
    end
    chk("halt_reached", seen_halt, 1'b1);
    chk("halt_read_en", imem_read_en, 1'b0);
    chk("halt_running", running, 1'b0);
    step();
    chk("halt_len", dl_d.size(), 4);
    if (dl_d.size() == 4) begin
      chk("halt_word_d", dl_d[3], HALT);
      chk("halt_word_pc", dl_pc[3], 65'd6);
    end
    chk("halt_drained", inst_valid, 1'b0);
    redir_valid = 1'b1; redir_pc = 65'd0;
    step();
    redir_valid = 1'b0; #1;
    chk("resume_running", running, 1'b1);
    chk("resume_read_en", imem_read_en, 1'b1);
    chk("resume_addr", imem_address, 65'd0);

    // PC wrap at the top of the address space
    redir_valid = 1'b1; redir_pc = top_pc;
    step();
    redir_valid = 1'b0; #1;
    chk("wrap_addr_top", imem_address, top_pc);
    chk("wrap_word_top", imem_address[8:1], 8'd255);
    dl_d.delete(); dl_pc.delete();
    step();
    chk("wrap_addr_zero", imem_address, 65'd0);
    chk("wrap_word_zero", imem_address[8:1], 8'd0);
    repeat (2) step();
    chk("wrap_len", dl_pc.size(), 2);
    if (dl_pc.size() == 2) begin
      chk("wrap_pc0", dl_pc[0], top_pc);
      chk("wrap_pc1", dl_pc[1], 65'd0);
      chk("wrap_d1", dl_d[1], 64'h11);
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
